pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and fetch sequencer that drives the 13-bit `prog_ctr` address into the instruction ROM, whose 9-bit machine code is returned combinationally in the same cycle. The block starts a program on command and advances sequentially. It applies absolute jumps and signed relative branches requested by the decoder, honours stalls, and ends the run on a halt request, reporting completion and a cycle count to the testbench/top level.

## Interface
- `D`, 12, PC width is D+1 bits (8192-word program space, matches ROM depth).
- `OFFW`, 8, width of signed relative branch offset.
- `CNTW`, 16, width of run cycle counter.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin program; honoured only in IDLE.
- `start_addr`  in  D+1  first instruction address, sampled with `start`.
- `stall`  in  1  hold PC this cycle.
- `jump_en`  in  1  absolute jump request.
- `jump_target`  in  D+1  jump destination.
- `branch_en`  in  1  relative branch request.
- `branch_off`  in  OFFW  signed two's-complement offset from current PC.
- `halt_req`  in  1  decoder has decoded halt at current PC.
- `prog_ctr`  out  D+1  ROM address (registered).
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle completion pulse.
- `trap`  out  1  PC range fault flag (see Configuration).
- `cycle_cnt`  out  CNTW  cycles spent in RUN for the last/current program.

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: `start`=1 -> RUN, `prog_ctr`<=`start_addr`, `cycle_cnt`<=0, `trap`<=0. Other control inputs ignored.
- RUN, per cycle, priority order:
  1. `halt_req` -> DONE, PC holds (even if `stall`=1).
  2. `stall` -> PC holds; jump/branch ignored this cycle (decoder re-asserts).
  3. `jump_en` -> PC<=`jump_target` (wins over `branch_en`).
  4. `branch_en` -> PC<=PC + sign-extend(`branch_off`).
  5. else PC<=PC+1.
- Arithmetic in D+1 bits, modulo 2^(D+1) unless the macro is defined.
- DONE: lasts exactly one cycle, `done`=1, then -> IDLE. `start` in RUN or DONE ignored.
- `cycle_cnt` increments every RUN cycle including stall cycles; saturates at 2^CNTW-1; holds value through DONE/IDLE until next accepted `start`.
- `prog_ctr` holds its last value in DONE and IDLE.

## Timing
- Reset values: `prog_ctr`=0, `busy`=0, `done`=0, `trap`=0, `cycle_cnt`=0; state IDLE. Reset mid-run aborts immediately, no `done`.
- All outputs registered; all inputs sampled on rising `clk`.
- `start` at edge N -> `prog_ctr`=`start_addr`, `busy`=1 after edge N; ROM code for it valid same cycle.
- Control inputs sampled in a cycle refer to the instruction at current `prog_ctr`; redirect visible after next edge (zero bubble, no delay slot).
- `halt_req` at edge N -> `done`=1, `busy`=0 after N; `done`=0 after N+1.

## Configuration
- `PC_RANGE_TRAP_EN` defined: an increment or branch whose true result leaves 0..2^(D+1)-1 does not update PC; block sets `trap`=1 and goes to DONE (`done` pulse next cycle as for halt). `trap` holds until next accepted `start` or reset. Jumps never trap.
- Not defined: PC wraps modulo 2^(D+1); `trap` tied 0.

## Test plan
- Reset: drive `rst_n`=0 mid-run at PC=40 -> all outputs return to reset values asynchronously; no `done` pulse.
- Sequential: `start`, `start_addr`=5, no controls 4 cycles -> `prog_ctr` 5,6,7,8; `cycle_cnt`=4 after 4th RUN cycle.
- Redirect: at PC=10 `branch_off`=-3 -> 7; at PC=7 `jump_en`=1, `jump_target`=100 with `branch_en`=1, `branch_off`=+2 -> 100.
- Stall/halt: `stall` 3 cycles at PC=20 -> PC stays 20, `cycle_cnt` +3; then `halt_req` with `stall`=1 -> `done` one cycle, `busy`=0, PC 20; `start` during DONE ignored.
- Wrap/trap: at PC=8191 increment -> without macro PC=0, `trap`=0; with `PC_RANGE_TRAP_EN` PC stays 8191, `trap`=1, `done` pulse. Branch from PC=2, `branch_off`=-5 -> 8189 without macro, trap with macro.
- Counter saturation: `CNTW`=4, run 20 cycles -> `cycle_cnt`=15 and holds after halt until next `start` clears it.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: program counter / fetch sequencer (IDLE->RUN->DONE). Define PC_RANGE_TRAP_EN to trap out-of-range increments and branches.
// Latency: redirects appear one edge after being sampled. Backpressure: stall holds the PC; there is no other flow control.
module pc_fetch #(
    parameter int D    = 12,
    parameter int OFFW = 8,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [D:0]        start_addr,
    input  logic              stall,
    input  logic              jump_en,
    input  logic [D:0]        jump_target,
    input  logic              branch_en,
    input  logic [OFFW-1:0]   branch_off,
    input  logic              halt_req,
    output logic [D:0]        prog_ctr,
    output logic              busy,
    output logic              done,
    output logic              trap,
    output logic [CNTW-1:0]   cycle_cnt
);
    localparam int PW = D + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [PW-1:0] pc_inc;
    logic [PW-1:0] pc_br;

    assign pc_inc = prog_ctr + PW'(1);

`ifdef PC_RANGE_TRAP_EN
    // Two guard bits hold the true, unwrapped branch result so that leaving the address space is visible.
    localparam int SW = PW + 2;
    logic [SW-1:0] br_wide;
    logic          br_oor;
    logic          inc_oor;

    assign br_wide = {2'b00, prog_ctr} + {{(SW-OFFW){branch_off[OFFW-1]}}, branch_off};
    assign pc_br   = br_wide[PW-1:0];
    assign br_oor  = (br_wide[SW-1:PW] != 2'b00);
    assign inc_oor = &prog_ctr;
`else
    assign pc_br = prog_ctr + {{(PW-OFFW){branch_off[OFFW-1]}}, branch_off};
    assign trap  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prog_ctr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cycle_cnt <= '0;
`ifdef PC_RANGE_TRAP_EN
            trap      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        prog_ctr  <= start_addr;
                        cycle_cnt <= '0;
`ifdef PC_RANGE_TRAP_EN
                        trap      <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + CNTW'(1);
                    end
                    if (halt_req) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (!stall) begin
                        if (jump_en) begin
                            prog_ctr <= jump_target;
                        end else if (branch_en) begin
`ifdef PC_RANGE_TRAP_EN
                            if (br_oor) begin
                                trap  <= 1'b1;
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                prog_ctr <= pc_br;
                            end
`else
                            prog_ctr <= pc_br;
`endif
                        end else begin
`ifdef PC_RANGE_TRAP_EN
                            if (inc_oor) begin
                                trap  <= 1'b1;
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                prog_ctr <= pc_inc;
                            end
`else
                            prog_ctr <= pc_inc;
`endif
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: a cycle-level reference model queues the expected outputs for each edge, and a monitor compares them.
`timescale 1ns/1ps
module tb_pc_fetch;
    localparam int D    = 12;
    localparam int OFFW = 8;
    localparam int CNTW = 4;
    localparam int PW   = D + 1;
    localparam int PMAX = (1 << PW) - 1;
    localparam int CMAX = (1 << CNTW) - 1;
`ifdef PC_RANGE_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic [PW-1:0]   start_addr = '0;
    logic            stall = 1'b0;
    logic            jump_en = 1'b0;
    logic [PW-1:0]   jump_target = '0;
    logic            branch_en = 1'b0;
    logic [OFFW-1:0] branch_off = '0;
    logic            halt_req = 1'b0;
    logic [PW-1:0]   prog_ctr;
    logic            busy;
    logic            done;
    logic            trap;
    logic [CNTW-1:0] cycle_cnt;

    pc_fetch #(.D(D), .OFFW(OFFW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .stall(stall), .jump_en(jump_en), .jump_target(jump_target),
        .branch_en(branch_en), .branch_off(branch_off), .halt_req(halt_req),
        .prog_ctr(prog_ctr), .busy(busy), .done(done), .trap(trap), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        bit busy;
        bit done;
        bit trap;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // The reference state is the observable outputs: busy marks a running program, and done marks the single completion cycle.
    int m_pc = 0;
    int m_cnt = 0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_trap = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step();
        int tgt;
        if (m_done) begin
            m_done = 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1;
                m_pc   = int'(start_addr);
                m_cnt  = 0;
                m_trap = 1'b0;
            end
        end else begin
            if (m_cnt < CMAX) m_cnt++;
            if (halt_req) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else if (!stall) begin
                if (jump_en)        tgt = int'(jump_target);
                else if (branch_en) tgt = m_pc + int'($signed(branch_off));
                else                tgt = m_pc + 1;
                if (tgt >= 0 && tgt <= PMAX) begin
                    m_pc = tgt;
                end else if (TRAP_EN) begin
                    m_trap = 1'b1;
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_pc = tgt & PMAX;
                end
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.pc = m_pc; e.busy = m_busy; e.done = m_done; e.trap = m_trap; e.cnt = m_cnt;
        sb.push_back(e);
    endfunction

    task automatic cyc(input bit s, input int sa, input bit st, input bit j, input int jt,
                       input bit b, input int off, input bit h);
        @(negedge clk);
        rst_n       = 1'b1;
        start       = s;
        start_addr  = PW'(sa);
        stall       = st;
        jump_en     = j;
        jump_target = PW'(jt);
        branch_en   = b;
        branch_off  = OFFW'(off);
        halt_req    = h;
        model_step();
        push_exp();
    endtask

    task automatic idle();
        cyc(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic halt();
        cyc(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
    endtask

    // Reset is asserted between edges, so the outputs must already be cleared before the next rising edge.
    task automatic reset_cyc();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0; stall = 1'b0; jump_en = 1'b0; branch_en = 1'b0; halt_req = 1'b0;
        #1;
        chk("async_rst_prog_ctr", int'(prog_ctr), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_trap", int'(trap), 0);
        chk("async_rst_cycle_cnt", int'(cycle_cnt), 0);
        m_pc = 0; m_cnt = 0; m_busy = 1'b0; m_done = 1'b0; m_trap = 1'b0;
        push_exp();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("prog_ctr", int'(prog_ctr), e.pc);
                chk("busy", int'(busy), int'(e.busy));
                chk("done", int'(done), int'(e.done));
                chk("trap", int'(trap), int'(e.trap));
                chk("cycle_cnt", int'(cycle_cnt), e.cnt);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        reset_cyc();
        reset_cyc();
        idle();

        // Sequential run from address 5
        cyc(1'b1, 5, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        repeat (4) idle();
        halt(); idle(); idle();

        // Redirects: a branch by -3, then a jump that wins over a simultaneous branch
        cyc(1'b1, 10, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, 0, 1'b1, -3, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 100, 1'b1, 2, 1'b0);
        halt(); idle();

        // Stalls, halt while stalled, and a start issued during DONE
        cyc(1'b1, 20, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        repeat (3) cyc(1'b0, 0, 1'b1, 1'b1, 500, 1'b1, 9, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
        cyc(1'b1, 77, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        idle(); idle();

        // Increment past the top of the address space
        cyc(1'b1, PMAX, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        idle(); idle(); halt(); idle(); idle();

        // Negative branch below address 0
        cyc(1'b1, 2, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, 0, 1'b1, -5, 1'b0);
        idle(); halt(); idle(); idle();

        // Counter saturation, held value after halt, and clearing on the next start
        cyc(1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        repeat (20) idle();
        halt();
        repeat (3) idle();
        cyc(1'b1, 3, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        idle(); halt(); idle();

        // Reset asserted mid-run at PC=40
        cyc(1'b1, 30, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        repeat (10) idle();
        reset_cyc();
        reset_cyc();
        idle(); idle();

        for (int i = 0; i < 1500; i++) begin
            int r;
            int sa;
            r = int'($urandom_range(0, 2));
            if (r == 0)      sa = int'($urandom_range(0, 6));
            else if (r == 1) sa = int'($urandom_range(PMAX - 6, PMAX));
            else             sa = int'($urandom_range(0, PMAX));
            cyc($urandom_range(0, 3) == 0, sa, $urandom_range(0, 4) == 0,
                $urandom_range(0, 7) == 0, int'($urandom_range(0, PMAX)),
                $urandom_range(0, 3) == 0, int'($urandom_range(0, 255)) - 128,
                $urandom_range(0, 29) == 0);
        end
        halt(); idle(); idle();

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
